// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: control-flow opcodes, branch funct3 encodings and
// the 2-bit branch-history counter states with their saturating update.
package riscv_pkg;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef enum logic [2:0] {
      BEQ  = 3'b000,
      BNE  = 3'b001,
      BLT  = 3'b100,
      BGE  = 3'b101,
      BLTU = 3'b110,
      BGEU = 3'b111
   } funct3_e;

   typedef enum logic [1:0] {
      STRONG_NT = 2'b00,
      WEAK_NT   = 2'b01,
      WEAK_T    = 2'b10,
      STRONG_T  = 2'b11
   } bht_state_e;

   typedef enum logic [1:0] {
      CLS_OTHER  = 2'b00,
      CLS_BRANCH = 2'b01,
      CLS_JUMP   = 2'b10
   } br_class_e;

   // Saturating step of a 2-bit counter towards the observed outcome.
   function automatic bht_state_e bht_next(input bht_state_e s, input logic taken);
      bht_state_e n;
      n = s;
      case (s)
         STRONG_NT: n = taken ? WEAK_NT  : STRONG_NT;
         WEAK_NT:   n = taken ? WEAK_T   : STRONG_NT;
         WEAK_T:    n = taken ? STRONG_T : WEAK_NT;
         STRONG_T:  n = taken ? STRONG_T : WEAK_T;
         default:   n = WEAK_NT;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table: array of 2-bit saturating counters with a
// combinational read port and one write port; async active-high reset.
module branch_bht
   import riscv_pkg::*;
#(
   parameter int ENTRIES = 16,
   localparam int IDX_W  = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx,
   output bht_state_e       rd_state,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             wr_en,
   input  logic             wr_taken
);

   bht_state_e cnt [ENTRIES];

   // NOTE: this array is reset entry by entry because its weak-not-taken start
   // state is visible on pred_taken; a RAM-style table without reset would not be.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            cnt[i] <= WEAK_NT;
         end
      end else if (wr_en) begin
         // NOTE: non-blocking so the same-cycle read still returns the old counter.
         cnt[wr_idx] <= bht_next(cnt[wr_idx], wr_taken);
      end
   end

   assign rd_state = cnt[rd_idx];

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution, 2-bit BHT prediction and optional profiling counters.
// Statistics counters are built only when BRANCH_STATS_EN is defined.
module branch_resolve
   import riscv_pkg::*;
#(
   parameter int BHT_ENTRIES = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic [31:0]      pc,
   input  logic             breq,
   input  logic             brlt,
   output logic             brun,
   output logic             pcsel,
   output logic             pred_taken,
   output logic             mispredict,
   output logic             illegal_br,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] taken_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);

   br_class_e        cls;
   logic             taken;
   logic             upd;
   logic [IDX_W-1:0] idx;
   bht_state_e       rd_state;
   logic             unused_pc_bits;

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case statements can infer a latch.
   always_comb begin
      cls = CLS_OTHER;
      case (opcode)
         OP_BRANCH:       cls = CLS_BRANCH;
         OP_JAL, OP_JALR: cls = CLS_JUMP;
         default:         cls = CLS_OTHER;
      endcase
   end

   always_comb begin
      taken      = 1'b0;
      illegal_br = 1'b0;
      brun       = 1'b0;
      if (cls == CLS_BRANCH) begin
         brun = (funct3[2:1] == 2'b11);
         case (funct3)
            BEQ:       taken = breq;
            BNE:       taken = !breq;
            BLT, BLTU: taken = brlt;
            BGE, BGEU: taken = !brlt;
            default:   illegal_br = 1'b1;
         endcase
      end
   end

   assign idx            = pc[IDX_W+1:2];
   assign unused_pc_bits = ^{pc[31:IDX_W+2], pc[1:0]};

   assign pcsel      = (cls == CLS_JUMP) || ((cls == CLS_BRANCH) && taken);
   assign pred_taken = rd_state[1];
   assign mispredict = (cls == CLS_BRANCH) && !illegal_br && (pred_taken != taken);
   assign upd        = en && (cls == CLS_BRANCH) && !illegal_br;

   branch_bht #(.ENTRIES(BHT_ENTRIES)) u_bht (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (idx),
      .rd_state (rd_state),
      .wr_idx   (idx),
      .wr_en    (upd),
      .wr_taken (taken)
   );

`ifdef BRANCH_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         branch_cnt  <= '0;
         taken_cnt   <= '0;
         mispred_cnt <= '0;
      end else if (upd) begin
         branch_cnt <= branch_cnt + CNT_W'(1);
         if (taken)      taken_cnt   <= taken_cnt + CNT_W'(1);
         if (mispredict) mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
   end
`else
   assign branch_cnt  = '0;
   assign taken_cnt   = '0;
   assign mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: a reference model pushes expected
// combinational outputs to a scoreboard queue; counts are checked after edges.
module tb_branch_resolve;

`ifdef BRANCH_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   localparam logic [6:0] OPB  = 7'b1100011;
   localparam logic [6:0] OPJ  = 7'b1101111;
   localparam logic [6:0] OPJR = 7'b1100111;
   localparam logic [6:0] OPR  = 7'b0110011;

   typedef struct packed {
      logic brun;
      logic pcsel;
      logic pred;
      logic mis;
      logic ill;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [31:0] pc;
   logic        breq;
   logic        brlt;
   logic        brun;
   logic        pcsel;
   logic        pred_taken;
   logic        mispredict;
   logic        illegal_br;
   logic [31:0] branch_cnt;
   logic [31:0] taken_cnt;
   logic [31:0] mispred_cnt;

   exp_t        exp_q[$];
   logic [1:0]  m_bht[16];
   logic [31:0] m_branch, m_taken, m_mis;
   int          n_checks = 0;
   int          n_pass   = 0;

   branch_resolve #(.BHT_ENTRIES(16), .CNT_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .opcode      (opcode),
      .funct3      (funct3),
      .pc          (pc),
      .breq        (breq),
      .brlt        (brlt),
      .brun        (brun),
      .pcsel       (pcsel),
      .pred_taken  (pred_taken),
      .mispredict  (mispredict),
      .illegal_br  (illegal_br),
      .branch_cnt  (branch_cnt),
      .taken_cnt   (taken_cnt),
      .mispred_cnt (mispred_cnt)
   );

   always #5 clk = ~clk;

   task automatic reset_model();
      for (int i = 0; i < 16; i++) m_bht[i] = 2'b01;
      m_branch = '0;
      m_taken  = '0;
      m_mis    = '0;
   endtask

   // Drive one instruction, push the model's expected outputs, and commit the
   // model state that the DUT will take on the next edge.
   task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] p,
                        input logic eq, input logic lt, input logic e);
      exp_t       x;
      logic       cond, jump, tk;
      logic [3:0] ix;
      opcode = op; funct3 = f3; pc = p; breq = eq; brlt = lt; en = e;
      cond = (op == OPB);
      jump = (op == OPJ) || (op == OPJR);
      case (f3)
         3'd0:       tk = eq;
         3'd1:       tk = !eq;
         3'd4, 3'd6: tk = lt;
         3'd5, 3'd7: tk = !lt;
         default:    tk = 1'b0;
      endcase
      ix     = p[5:2];
      x.ill  = cond && (f3 == 3'd2 || f3 == 3'd3);
      x.brun = cond && (f3 == 3'd6 || f3 == 3'd7);
      x.pcsel = jump || (cond && !x.ill && tk);
      x.pred = m_bht[ix][1];
      x.mis  = cond && !x.ill && (x.pred != tk);
      exp_q.push_back(x);
      if (e && cond && !x.ill && !rst) begin
         m_branch++;
         if (tk)    m_taken++;
         if (x.mis) m_mis++;
         if (tk) m_bht[ix] = (m_bht[ix] == 2'b11) ? 2'b11 : m_bht[ix] + 2'b01;
         else    m_bht[ix] = (m_bht[ix] == 2'b00) ? 2'b00 : m_bht[ix] - 2'b01;
      end
   endtask

   task automatic test_reset();
      exp_t x, obs;
      rst = 1'b1;
      reset_model();
      drive(7'd0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0);
      #1;
      x = exp_q.pop_front();
      obs = {brun, pcsel, pred_taken, mispredict, illegal_br};
      n_checks++;
      if (obs !== x) $display("FAIL reset_outputs: got %b want %b", obs, x);
      else n_pass++;
      n_checks++;
      if ({branch_cnt, taken_cnt, mispred_cnt} !== 96'd0)
         $display("FAIL reset_counts: got %0d/%0d/%0d want 0/0/0", branch_cnt, taken_cnt, mispred_cnt);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   // One table row: op, f3, pc, breq, brlt, en.
   typedef struct {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [31:0] p;
      logic        eq, lt, e;
   } stim_t;

   task automatic run_table(input string name, input stim_t tbl[$]);
      exp_t x, obs;
      foreach (tbl[i]) begin
         drive(tbl[i].op, tbl[i].f3, tbl[i].p, tbl[i].eq, tbl[i].lt, tbl[i].e);
         #1;
         x = exp_q.pop_front();
         obs = {brun, pcsel, pred_taken, mispredict, illegal_br};
         n_checks++;
         if (obs !== x) $display("FAIL %s[%0d] brun,pcsel,pred,mis,ill: got %b want %b", name, i, obs, x);
         else n_pass++;
         @(posedge clk); #1;
         n_checks++;
         if ({branch_cnt, taken_cnt, mispred_cnt} !==
             (STATS ? {m_branch, m_taken, m_mis} : 96'd0))
            $display("FAIL %s[%0d] counts: got %0d/%0d/%0d want %0d/%0d/%0d", name, i,
                     branch_cnt, taken_cnt, mispred_cnt,
                     STATS ? m_branch : 0, STATS ? m_taken : 0, STATS ? m_mis : 0);
         else n_pass++;
      end
   endtask

   task automatic test_first_beq();
      stim_t t[$];
      t.push_back('{OPB, 3'd0, 32'h100, 1'b1, 1'b0, 1'b1});
      t.push_back('{OPB, 3'd0, 32'h100, 1'b1, 1'b0, 1'b0});
      run_table("first_beq", t);
   endtask

   task automatic test_brun_select();
      stim_t t[$];
      t.push_back('{OPB, 3'd7, 32'h200, 1'b0, 1'b0, 1'b1});
      t.push_back('{OPB, 3'd4, 32'h204, 1'b0, 1'b1, 1'b1});
      t.push_back('{OPB, 3'd6, 32'h208, 1'b0, 1'b0, 1'b1});
      t.push_back('{OPB, 3'd1, 32'h20c, 1'b1, 1'b0, 1'b1});
      t.push_back('{OPB, 3'd5, 32'h210, 1'b0, 1'b1, 1'b1});
      run_table("brun_select", t);
   endtask

   task automatic test_saturation();
      stim_t t[$];
      for (int i = 0; i < 5; i++) t.push_back('{OPB, 3'd1, 32'h300, 1'b0, 1'b0, 1'b1});
      t.push_back('{OPB, 3'd1, 32'h300, 1'b1, 1'b0, 1'b1});
      run_table("saturation", t);
   endtask

   task automatic test_jump_illegal();
      stim_t t[$];
      t.push_back('{OPJ,  3'd0, 32'h100, 1'b1, 1'b0, 1'b1});
      t.push_back('{OPB,  3'd2, 32'h100, 1'b1, 1'b0, 1'b1});
      t.push_back('{OPB,  3'd3, 32'h100, 1'b0, 1'b1, 1'b1});
      t.push_back('{OPJR, 3'd1, 32'h100, 1'b0, 1'b0, 1'b1});
      t.push_back('{OPR,  3'd0, 32'h100, 1'b1, 1'b0, 1'b1});
      t.push_back('{OPB,  3'd0, 32'h100, 1'b0, 1'b0, 1'b0});
      run_table("jump_illegal", t);
   endtask

   task automatic test_en_low();
      stim_t t[$];
      t.push_back('{OPB, 3'd0, 32'h400, 1'b1, 1'b0, 1'b0});
      t.push_back('{OPB, 3'd0, 32'h400, 1'b1, 1'b0, 1'b0});
      run_table("en_low", t);
   endtask

   task automatic test_async_reset();
      exp_t  x, obs;
      stim_t t[$];
      drive(OPB, 3'd0, 32'h300, 1'b1, 1'b0, 1'b0);
      void'(exp_q.pop_front());
      #2 rst = 1'b1;
      #1;
      reset_model();
      n_checks++;
      if ({branch_cnt, taken_cnt, mispred_cnt} !== 96'd0)
         $display("FAIL async_reset counts: got %0d/%0d/%0d want 0/0/0", branch_cnt, taken_cnt, mispred_cnt);
      else n_pass++;
      drive(OPB, 3'd0, 32'h300, 1'b1, 1'b0, 1'b0);
      #1;
      x = exp_q.pop_front();
      obs = {brun, pcsel, pred_taken, mispredict, illegal_br};
      n_checks++;
      if (obs !== x) $display("FAIL async_reset entry: got %b want %b", obs, x);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      t.push_back('{OPB, 3'd0, 32'h300, 1'b1, 1'b0, 1'b1});
      t.push_back('{OPB, 3'd0, 32'h300, 1'b0, 1'b0, 1'b1});
      t.push_back('{OPB, 3'd0, 32'h300, 1'b0, 1'b0, 1'b1});
      run_table("after_reset", t);
   endtask

   task automatic test_random();
      stim_t       t[$];
      logic [6:0]  ops[4];
      ops[0] = OPB; ops[1] = OPB; ops[2] = OPJ; ops[3] = OPR;
      for (int i = 0; i < 16; i++) begin
         t.push_back('{ops[$urandom_range(0, 3)], 3'($urandom_range(0, 7)),
                       32'h500 + 32'($urandom_range(0, 3) * 4),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 7) != 0)});
      end
      run_table("random", t);
   endtask

   initial begin
      en = 1'b0; opcode = '0; funct3 = '0; pc = '0; breq = 1'b0; brlt = 1'b0;
      test_reset();
      test_first_beq();
      test_brun_select();
      test_saturation();
      test_jump_illegal();
      test_en_low();
      test_async_reset();
      test_random();
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Branch resolution and profiling stage directly downstream of the branch comparator in the single-cycle RV32I datapath.
- Decodes opcode/funct3 into the comparator's unsigned-select (`brun`) and turns the returned `breq`/`brlt` into the PC-select decision.
- Keeps a PC-indexed table of 2-bit saturating counters that predicts each conditional branch and flags mispredictions, as groundwork for a pipelined front end.
- Optionally counts retired branches, taken branches and mispredictions for performance profiling.

## Interface
- `BHT_ENTRIES`, 16, number of 2-bit counters; power of two, ≥2.
- `CNT_W`, 32, width of each statistics counter.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  current instruction retires this cycle; gates all state updates.
- `opcode`  in  7  instruction[6:0].
- `funct3`  in  3  instruction[14:12].
- `pc`  in  32  PC of the current instruction.
- `breq`  in  1  equality result from the branch comparator.
- `brlt`  in  1  less-than result from the branch comparator.
- `brun`  out  1  unsigned-compare select to the branch comparator.
- `pcsel`  out  1  1 = next PC is the ALU target; 0 = PC+4.
- `pred_taken`  out  1  BHT prediction for `pc`.
- `mispredict`  out  1  conditional branch whose outcome differs from `pred_taken`.
- `illegal_br`  out  1  branch opcode with reserved funct3 (010/011).
- `branch_cnt`  out  CNT_W  retired conditional branches.
- `taken_cnt`  out  CNT_W  retired taken conditional branches.
- `mispred_cnt`  out  CNT_W  retired mispredicted branches.

## Operation
- Classes, from `opcode`:
  - 1100011 = conditional branch.
  - 1101111 (JAL) and 1100111 (JALR) = jump.
  - Anything else = other.
- `brun` = 1 only for a conditional branch with funct3 110 or 111; otherwise 0.
- Taken by funct3:
  - 000 (BEQ): `breq`.
  - 001 (BNE): !`breq`.
  - 100 (BLT) and 110 (BLTU): `brlt`.
  - 101 (BGE) and 111 (BGEU): !`brlt`.
  - 010 and 011: not taken, and `illegal_br` = 1.
- `pcsel` = 1 for any jump or for a taken conditional branch; 0 otherwise. `pcsel` does not depend on `en`.
- BHT index = `pc[$clog2(BHT_ENTRIES)+1:2]`.
- `pred_taken` = bit 1 of the indexed counter, read combinationally.
- Counter states are 00 strong-NT, 01 weak-NT, 10 weak-T and 11 strong-T.
  - Taken increments the counter and saturates at 11.
  - Not-taken decrements it and saturates at 00.
- BHT update occurs when `en`, the class is conditional branch, and `illegal_br` = 0. Jumps, illegal branches and other instructions never touch the BHT.
- `mispredict` = conditional branch && !`illegal_br` && (`pred_taken` != taken). It is 0 for every other case.
- Statistics (when compiled in) are qualified by the same condition as the BHT update:
  - `branch_cnt` += 1 per qualifying branch.
  - `taken_cnt` += 1 if the branch is taken.
  - `mispred_cnt` += 1 if `mispredict`.
  - All counters wrap modulo 2^CNT_W.

## Timing
- `brun`, `pcsel`, `pred_taken`, `mispredict` and `illegal_br` are combinational, with zero latency, within the same cycle as the inputs.
- BHT entries and statistics counters update on the rising `clk` edge and are visible the next cycle.
- Read-during-update to the same index: the current cycle sees the old counter; the next cycle sees the new one.
- `en` = 0: no state changes, but combinational outputs remain valid.
- Reset values, applied immediately on `rst` assertion (including mid-operation):
  - All BHT entries are 01.
  - All three counters are 0.
  - With `opcode`=0, outputs are `brun`=0, `pcsel`=0, `pred_taken`=0, `mispredict`=0 and `illegal_br`=0.
- First edge after `rst` deassertion with `en`=1 performs a normal update.

## Configuration
- `BRANCH_STATS_EN` defined: the three statistics counters are implemented as described.
- `BRANCH_STATS_EN` undefined: no counter flops are generated; `branch_cnt`, `taken_cnt` and `mispred_cnt` are tied to 0. Port list is unchanged.

## Structure
- Shared package `riscv_pkg` holds:
  - Opcode constants: OP_BRANCH, OP_JAL, OP_JALR.
  - funct3 enum: BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - 2-bit counter state typedef with the four named states.
- Sub-module `branch_bht`: counter array with async reset, combinational read port and a single write port taking index, update-enable and taken.
- Top level holds the decode, taken logic and statistics.

## Test plan
- After reset, BEQ at pc=0x100 with `breq`=1, `en`=1 → `pcsel`=1, `pred_taken`=0, `mispredict`=1; next cycle the entry is 10 and `mispred_cnt`=1.
- BGEU with `brlt`=0 → `brun`=1, `pcsel`=1. BLT with `brlt`=1 → `brun`=0, `pcsel`=1.
- Four consecutive taken BNE at the same pc → entry saturates at 11; a 5th taken gives 11 with `mispredict`=0; `branch_cnt`=5, `taken_cnt`=5.
- JAL, then funct3=010 on a branch opcode → `pcsel`=1, then `pcsel`=0 with `illegal_br`=1; BHT and counters are unchanged in both cases.
- `en`=0 on a taken BEQ → `pcsel`=1, no state change. Then assert `rst` mid-cycle → counters clear to 0 and entries return to 01 without waiting for a clock edge.
- Build without `BRANCH_STATS_EN` and run 10 branches → all count outputs stay 0 while `pcsel` and `mispredict` behave identically.
